compressed_line_packer: RTL and testbench

- Sits directly downstream of the length-generation stage in the Stage1+2 compressor.
- Each accepted beat carries two variable-length compressed fields, each right-aligned with a bit length. Lengths come from the per-word length generators; field payloads come from the encoder datapath.
- Appends both fields LSB-first into a 256-bit staging buffer and emits 128-bit output lines via valid/ready.
- On flush (end of a cache-line group), zero-pads and emits the partial tail line.

---
 rtl/compressed_line_packer_if.sv | 38 +++
 rtl/compressed_line_packer.sv | 210 +++++++++++++++++++++
 tb/tb_compressed_line_packer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/compressed_line_packer_if.sv
// compressed_line_packer_if
// Handshake and data bundle for the compressed line packer.
//   Input beat side : i_valid / o_ready, two right-aligned fields with bit
//                     lengths (i_length1/i_data1, i_length2/i_data2), and a
//                     single-cycle i_flush drain request.
//   Output line side: o_valid / i_ready, o_line (bit 0 oldest), o_line_bits,
//                     o_last (final line of a flush), o_flush_done pulse.
//   slave  modport : seen by the packer.
//   master modport : seen by whatever drives the packer (encoder + sink).
interface compressed_line_packer_if #(
  parameter int CACHE_LINE = 128,
  parameter int MAX_LEN    = 40,
  parameter int LEN_W      = 6
);
  logic                  i_valid;
  logic                  o_ready;
  logic [LEN_W-1:0]      i_length1;
  logic [MAX_LEN-1:0]    i_data1;
  logic [LEN_W-1:0]      i_length2;
  logic [MAX_LEN-1:0]    i_data2;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic [CACHE_LINE-1:0] o_line;
  logic [7:0]            o_line_bits;
  logic                  o_last;
  logic                  o_flush_done;

  modport slave (
    input  i_valid, i_length1, i_data1, i_length2, i_data2, i_flush, i_ready,
    output o_ready, o_valid, o_line, o_line_bits, o_last, o_flush_done
  );

  modport master (
    output i_valid, i_length1, i_data1, i_length2, i_data2, i_flush, i_ready,
    input  o_ready, o_valid, o_line, o_line_bits, o_last, o_flush_done
  );
endinterface

// File: rtl/compressed_line_packer.sv
// compressed_line_packer
// Appends two variable-length fields per accepted beat, LSB-first, into a
// staging buffer twice the line width and emits full lines. A flush drains
// the tail as zero-padded partial lines, then pulses o_flush_done.
//   i_clk   : clock
//   i_reset : asynchronous active-low reset
//   bus     : compressed_line_packer_if.slave (beat input, line output)
// All outputs are registered: the output flops are loaded from the next
// state, so a beat accepted in cycle N is visible in o_line at cycle N+1.
module compressed_line_packer #(
  parameter int CACHE_LINE = 128,
  parameter int MAX_LEN    = 40,
  parameter int LEN_W      = 6
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  compressed_line_packer_if.slave   bus
);
  localparam int BUF_W     = 2 * CACHE_LINE;
  localparam int FILL_W    = $clog2(BUF_W + 1);
  // Highest fill at which two maximum-length fields still fit.
  localparam int READY_MAX = BUF_W - 2 * MAX_LEN;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Clamp an incoming length to MAX_LEN, widened to the fill width.
  function automatic logic [FILL_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [FILL_W-1:0] ext;
    ext = FILL_W'(len);
    if (ext > FILL_W'(MAX_LEN)) begin
      return FILL_W'(MAX_LEN);
    end else begin
      return ext;
    end
  endfunction

  // Zero payload bits at or above the effective length; widen to buffer width.
  function automatic logic [BUF_W-1:0] field_bits(input logic [MAX_LEN-1:0] data,
                                                  input logic [FILL_W-1:0]  len);
    logic [BUF_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      r[i] = (FILL_W'(i) < len) ? data[i] : 1'b0;
    end
    return r;
  endfunction

  // Keep only the lowest n bits of a line.
  function automatic logic [CACHE_LINE-1:0] keep_low(input logic [CACHE_LINE-1:0] v,
                                                     input logic [FILL_W-1:0]     n);
    logic [CACHE_LINE-1:0] r;
    for (int i = 0; i < CACHE_LINE; i++) begin
      r[i] = (FILL_W'(i) < n) ? v[i] : 1'b0;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [7:0]            line_bits_q, line_bits_d;
  logic                  last_q, last_d;
  logic                  flush_done_q, flush_done_d;

  logic                  accept_s;
  logic                  out_hs_s;
  logic [FILL_W-1:0]     len1_s, len2_s;
  logic [BUF_W-1:0]      f1_s, f2_s;
  logic [FILL_W-1:0]     take_s;
  logic [FILL_W-1:0]     take_next_s;

  // Next buffer/fill/state, then the registered output values from that next state.
  always_comb begin
    accept_s    = bus.i_valid & ready_q;
    out_hs_s    = valid_q & bus.i_ready;
    len1_s      = clamp_len(bus.i_length1);
    len2_s      = clamp_len(bus.i_length2);
    f1_s        = field_bits(bus.i_data1, len1_s);
    f2_s        = field_bits(bus.i_data2, len2_s);
    take_s      = (fill_q > FILL_W'(CACHE_LINE)) ? FILL_W'(CACHE_LINE) : fill_q;
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;

    case (state_q)
      ST_ACCUM: begin
        // Pop first so a same-cycle beat lands at fill - CACHE_LINE.
        if (out_hs_s) begin
          buf_d  = buf_q >> CACHE_LINE;
          fill_d = fill_q - FILL_W'(CACHE_LINE);
        end else begin
          buf_d  = buf_q;
          fill_d = fill_q;
        end
        if (accept_s) begin
          buf_d  = buf_d | (f1_s << fill_d) | (f2_s << (fill_d + len1_s));
          fill_d = fill_d + len1_s + len2_s;
        end else begin
          fill_d = fill_d;
        end
        if (bus.i_flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (fill_q == '0) begin
          state_d = ST_DONE;
        end else if (out_hs_s) begin
          buf_d  = buf_q >> CACHE_LINE;
          fill_d = fill_q - take_s;
          if (fill_q <= FILL_W'(CACHE_LINE)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_ACCUM;
        buf_d   = '0;
        fill_d  = '0;
      end
      default: begin
        state_d = ST_ACCUM;
        buf_d   = '0;
        fill_d  = '0;
      end
    endcase

    take_next_s = (fill_d > FILL_W'(CACHE_LINE)) ? FILL_W'(CACHE_LINE) : fill_d;

    case (state_d)
      ST_ACCUM: begin
        ready_d      = (fill_d <= FILL_W'(READY_MAX));
        valid_d      = (fill_d >= FILL_W'(CACHE_LINE));
        line_d       = buf_d[CACHE_LINE-1:0];
        line_bits_d  = 8'(CACHE_LINE);
        last_d       = 1'b0;
        flush_done_d = 1'b0;
      end
      ST_DRAIN: begin
        ready_d      = 1'b0;
        valid_d      = (fill_d != '0);
        line_d       = keep_low(buf_d[CACHE_LINE-1:0], take_next_s);
        line_bits_d  = 8'(take_next_s);
        last_d       = (fill_d != '0) && (fill_d <= FILL_W'(CACHE_LINE));
        flush_done_d = 1'b0;
      end
      ST_DONE: begin
        ready_d      = 1'b0;
        valid_d      = 1'b0;
        line_d       = '0;
        line_bits_d  = 8'd0;
        last_d       = 1'b0;
        flush_done_d = 1'b1;
      end
      default: begin
        ready_d      = 1'b0;
        valid_d      = 1'b0;
        line_d       = '0;
        line_bits_d  = 8'd0;
        last_d       = 1'b0;
        flush_done_d = 1'b0;
      end
    endcase
  end

  // State, staging buffer and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_ACCUM;
      buf_q        <= '0;
      fill_q       <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      line_q       <= '0;
      line_bits_q  <= 8'd0;
      last_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      line_q       <= line_d;
      line_bits_q  <= line_bits_d;
      last_q       <= last_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_line       = line_q;
  assign bus.o_line_bits  = line_bits_q;
  assign bus.o_last       = last_q;
  assign bus.o_flush_done = flush_done_q;
endmodule

// File: tb/tb_compressed_line_packer.sv
// Self-checking bench for compressed_line_packer. The reference model keeps
// the pending bitstream as a queue of bits (oldest at the front) and derives
// every expected output from it each cycle.
module tb_compressed_line_packer;
  logic clk;
  logic rst_n;

  compressed_line_packer_if bus ();

  compressed_line_packer dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model: pending bits and mode (0 accumulate, 1 drain, 2 done).
  bit mq[$];
  int mode;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_field(input logic [5:0] len, input logic [39:0] d);
    int eff;
    eff = (len > 6'd40) ? 40 : int'(len);
    for (int i = 0; i < eff; i++) mq.push_back(d[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_ready"}, 128'(bus.o_ready), 128'd1);
    check_val({tag, "_valid"}, 128'(bus.o_valid), 128'd0);
    check_val({tag, "_done"},  128'(bus.o_flush_done), 128'd0);
    check_val({tag, "_last"},  128'(bus.o_last), 128'd0);
    check_val({tag, "_line"},  bus.o_line, 128'd0);
    check_val({tag, "_bits"},  128'(bus.o_line_bits), 128'd0);
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic cycle(input logic v, input logic [5:0] l1, input logic [39:0] d1,
                       input logic [5:0] l2, input logic [39:0] d2,
                       input logic fl, input logic rdy);
    int sz, n;
    logic e_ready, e_valid, e_last, e_done;
    logic [127:0] e_line;
    logic [7:0] e_bits;
    bit acc, hs;
    bus.i_valid   = v;
    bus.i_length1 = l1;
    bus.i_data1   = d1;
    bus.i_length2 = l2;
    bus.i_data2   = d2;
    bus.i_flush   = fl;
    bus.i_ready   = rdy;
    @(negedge clk);
    sz = mq.size();
    e_line = '0;
    case (mode)
      0: begin
        e_ready = (sz <= 176); e_valid = (sz >= 128); n = (sz < 128) ? sz : 128;
        e_bits = 8'd128; e_last = 1'b0; e_done = 1'b0;
      end
      1: begin
        e_ready = 1'b0; e_valid = (sz > 0); n = (sz < 128) ? sz : 128;
        e_bits = 8'(n); e_last = (sz > 0) && (sz <= 128); e_done = 1'b0;
      end
      default: begin
        e_ready = 1'b0; e_valid = 1'b0; n = 0;
        e_bits = 8'd0; e_last = 1'b0; e_done = 1'b1;
      end
    endcase
    for (int i = 0; i < n; i++) e_line[i] = mq[i];
    check_val("ready", 128'(bus.o_ready), 128'(e_ready));
    check_val("valid", 128'(bus.o_valid), 128'(e_valid));
    check_val("flush_done", 128'(bus.o_flush_done), 128'(e_done));
    if (mode == 0 || e_valid) begin
      check_val("line", bus.o_line, e_line);
      check_val("line_bits", 128'(bus.o_line_bits), 128'(e_bits));
      check_val("last", 128'(bus.o_last), 128'(e_last));
    end
    acc = v && e_ready;
    hs  = e_valid && rdy;
    @(posedge clk);
    case (mode)
      0: begin
        if (hs) repeat (128) void'(mq.pop_front());
        if (acc) begin
          push_field(l1, d1);
          push_field(l2, d2);
        end
        if (fl) mode = 1;
      end
      1: begin
        if (sz == 0) mode = 2;
        else if (hs) begin
          repeat (n) void'(mq.pop_front());
          if (sz <= 128) mode = 2;
        end
      end
      default: begin
        mode = 0;
        mq.delete();
      end
    endcase
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 6'd0, 40'd0, 6'd0, 40'd0, 1'b0, rdy);
  endtask

  initial begin
    logic [63:0] r1, r2;
    logic [127:0] cap;
    logic [39:0] da, db;
    n_checks = 0;
    n_errors = 0;
    mode = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_length1 = '0; bus.i_data1 = '0;
    bus.i_length2 = '0; bus.i_data2 = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    #12;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four 16+16 beats form exactly one line.
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'd16, 40'hAAAA, 6'd16, 40'h5555, 1'b0, 1'b1);
    check_val("tp_line_pattern", bus.o_line, {4{32'h5555AAAA}});
    check_val("tp_line_bits128", 128'(bus.o_line_bits), 128'd128);
    idle(1'b1);
    check_val("tp_drained_valid", 128'(bus.o_valid), 128'd0);

    // Partial line with masked payload, then flush.
    cycle(1'b1, 6'd20, 40'hFF_FFFF_FFFF, 6'd0, 40'hFF_FFFF_FFFF, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 40'd0, 6'd0, 40'd0, 1'b1, 1'b0);
    check_val("tp_tail_line", bus.o_line, 128'hFFFFF);
    check_val("tp_tail_bits", 128'(bus.o_line_bits), 128'd20);
    check_val("tp_tail_last", 128'(bus.o_last), 128'd1);
    idle(1'b1);
    check_val("tp_tail_done", 128'(bus.o_flush_done), 128'd1);
    idle(1'b1);
    check_val("tp_tail_ready", 128'(bus.o_ready), 128'd1);

    // Flush on an empty buffer: no line, done pulse two cycles later.
    cycle(1'b0, 6'd0, 40'd0, 6'd0, 40'd0, 1'b1, 1'b1);
    idle(1'b1);
    check_val("tp_empty_done", 128'(bus.o_flush_done), 128'd1);
    idle(1'b1);

    // Maximum-length beats under backpressure: only three fit.
    for (int i = 0; i < 4; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      cycle(1'b1, 6'd40, r1[39:0], 6'd40, r2[39:0], 1'b0, 1'b0);
    end
    check_val("tp_full_ready", 128'(bus.o_ready), 128'd0);
    idle(1'b1);
    check_val("tp_after_pop_ready", 128'(bus.o_ready), 128'd1);
    check_val("tp_after_pop_valid", 128'(bus.o_valid), 128'd0);
    cycle(1'b0, 6'd0, 40'd0, 6'd0, 40'd0, 1'b1, 1'b1);
    check_val("tp_drain112_bits", 128'(bus.o_line_bits), 128'd112);
    idle(1'b1);
    idle(1'b1);

    // Simultaneous accept and output at fill 128.
    for (int i = 0; i < 4; i++) begin
      r1 = {$urandom(), $urandom()};
      cycle(1'b1, 6'd16, r1[39:0], 6'd16, r1[63:24], 1'b0, 1'b0);
    end
    da = 40'(($urandom() & 32'hFF) | 32'h1);
    db = 40'(($urandom() & 32'hFF) | 32'h80);
    cycle(1'b1, 6'd8, da, 6'd8, db, 1'b0, 1'b1);
    cap = bus.o_line;
    check_val("tp_simul_low16", 128'(cap[15:0]), 128'({db[7:0], da[7:0]}));
    check_val("tp_simul_valid", 128'(bus.o_valid), 128'd0);

    // Randomized traffic, including clamped lengths and occasional flushes.
    for (int k = 0; k < 1500; k++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      cycle($urandom_range(0, 9) < 7,
            ($urandom_range(0, 3) == 0) ? 6'd40 : 6'($urandom_range(0, 63)), r1[39:0],
            ($urandom_range(0, 3) == 0) ? 6'd40 : 6'($urandom_range(0, 63)), r2[39:0],
            $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6);
    end
    for (int k = 0; k < 6; k++) idle(1'b1);

    // Reset asserted mid-drain discards everything immediately.
    for (int i = 0; i < 5; i++) begin
      r1 = {$urandom(), $urandom()};
      cycle(1'b1, 6'd40, r1[39:0], 6'd40, r1[63:24], 1'b0, 1'b0);
    end
    cycle(1'b0, 6'd0, 40'd0, 6'd0, 40'd0, 1'b1, 1'b0);
    check_val("tp_pre_reset_valid", 128'(bus.o_valid), 128'd1);
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
